cond_complement_seq: RTL and testbench

//  Parametrised, sequential conditional-complement unit for the Booth multiplier datapath.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/cond_complement_seq_slice.sv | 14 +
 rtl/cond_complement_seq.sv | 142 ++++++++++++++
 tb/tb_cond_complement_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath: complement modes,
// conditional-complement FSM states and the parameter sanity check.
package booth_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_TWOS = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } cc_state_t;

    // The word must split into a whole, non-zero number of slices.
    function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/cond_complement_seq_slice.sv
// CHUNK-bit combinational incrementer used to ripple the +1 carry one slice
// per cycle.
module complement_slice #(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/cond_complement_seq.sv
// Sequential conditional complement (pass / ones / twos / abs). The word is
// inverted on accept, then the +1 carry ripples through one CHUNK slice per cycle.
module cond_complement_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(NSLICE) + 1;

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("cond_complement_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    cc_state_t        r_state;
    cc_state_t        w_next;
    logic [WIDTH-1:0] r_word;
    logic             r_carry;
    logic             r_ovf;
    logic [CW-1:0]    r_idx;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_neg;
    logic             w_inv;
    logic             w_most_neg;
    logic [CHUNK-1:0] w_slice_a;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_cout;
    logic [WIDTH-1:0] w_word_upd;

    assign w_neg      = (in_mode == MODE_TWOS) | ((in_mode == MODE_ABS) & in_data[WIDTH-1]);
    assign w_inv      = w_neg | (in_mode == MODE_ONES);
    // Most-negative: MSB set and every other bit clear.
    assign w_most_neg = in_data[WIDTH-1] & ((in_data << 1) == '0);
    assign w_last     = (r_idx == CW'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        w_step    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                w_accept  = out_ready & in_valid;
                if (out_ready) begin
                    w_next = in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_slice_a = '0;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            if (r_idx == CW'(k)) begin
                w_slice_a = r_word[k*CHUNK +: CHUNK];
            end
        end
    end

    complement_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (w_slice_a),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_comb begin
        w_word_upd = r_word;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            if (r_idx == CW'(k)) begin
                w_word_upd[k*CHUNK +: CHUNK] = w_slice_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_word  <= in_data ^ {WIDTH{w_inv}};
            r_carry <= w_neg;
            r_ovf   <= w_neg & w_most_neg;
            r_idx   <= '0;
        end else if (w_step) begin
            r_word  <= w_word_upd;
            r_carry <= w_slice_cout;
            r_idx   <= r_idx + 1'b1;
        end
    end

    assign out_data  = r_word;
    assign out_carry = r_carry;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_cond_complement_seq.sv
// Self-checking bench for cond_complement_seq (WIDTH=64, CHUNK=16) against an
// arithmetic reference model.
module tb_cond_complement_seq;
    import booth_pkg::*;

    localparam int unsigned W = 64;
    localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_carry;
    logic          out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    cond_complement_seq #(
        .WIDTH (64),
        .CHUNK (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, carry, result} from plain two's-complement arithmetic.
    function automatic logic [65:0] model(input logic [63:0] d, input logic [1:0] m);
        logic [63:0] o;
        logic        c;
        logic        v;
        o = d;
        c = 1'b0;
        v = 1'b0;
        case (m)
            MODE_ONES: o = ~d;
            MODE_TWOS: begin
                o = 64'd0 - d;
                c = (d == 64'd0);
                v = (d == MINNEG);
            end
            MODE_ABS: begin
                if ($signed(d) < 0) begin
                    o = 64'd0 - d;
                    v = (d == MINNEG);
                end
            end
            default: o = d;
        endcase
        return {v, c, o};
    endfunction

    // Offers one operand; returns once it is accepted (or the bound expires).
    task automatic send(input logic [63:0] d, input logic [1:0] m, output bit timeout);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        timeout = !in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_mode  = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [63:0] d, input logic [1:0] m,
                            input bool_check_lat);
        bit          to;
        int          cyc;
        logic [65:0] exp;
        exp = model(d, m);
        send(d, m, to);
        wait_valid(cyc);
        n_tests++;
        if (to || !out_valid || (bool_check_lat && cyc != 4)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles (valid=%b) expected 4", name, cyc, out_valid);
        end
        n_tests++;
        if ({out_ovf, out_carry, out_data} !== exp) begin
            n_fail++;
            $display("FAIL %s result: got ovf=%b carry=%b data=%h expected ovf=%b carry=%b data=%h",
                     name, out_ovf, out_carry, out_data, exp[65], exp[64], exp[63:0]);
        end
        retire();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_tests++;
        if ({out_valid, in_ready, out_carry, out_ovf, out_data} !== {1'b0, 1'b1, 1'b0, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset: got valid=%b ready=%b carry=%b ovf=%b data=%h expected 0 1 0 0 0",
                     out_valid, in_ready, out_carry, out_ovf, out_data);
        end
    endtask

    task automatic test_directed();
        check_op("twos_one",  64'h0000_0000_0000_0001, MODE_TWOS, 1'b1);
        check_op("twos_zero", 64'h0,                   MODE_TWOS, 1'b1);
        check_op("abs_minneg", MINNEG,                 MODE_ABS,  1'b1);
        check_op("abs_neg",   64'hFFFF_FFFF_FFFF_FFF6, MODE_ABS,  1'b1);
        check_op("abs_pos",   64'h0000_0000_0000_0007, MODE_ABS,  1'b1);
        check_op("ones",      64'hF0F0_F0F0_F0F0_F0F0, MODE_ONES, 1'b1);
        check_op("pass",      64'h1234_5678_9ABC_DEF0, MODE_PASS, 1'b1);
        check_op("twos_minneg", MINNEG,                MODE_TWOS, 1'b1);
    endtask

    task automatic test_backpressure();
        bit          to;
        int          cyc;
        logic [63:0] da;
        logic [63:0] db;
        logic [65:0] ea;
        logic [65:0] eb;
        da = 64'h0000_0000_0000_0123;
        db = 64'hFFFF_FFFF_0000_0000;
        ea = model(da, MODE_TWOS);
        eb = model(db, MODE_ABS);
        send(da, MODE_TWOS, to);
        wait_valid(cyc);
        for (int i = 0; i < 3; i++) begin
            in_data = {$urandom, $urandom};
            @(posedge clk); #1;
            n_tests++;
            if (!out_valid || in_ready || {out_ovf, out_carry, out_data} !== ea) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h expected valid=1 ready=0 data=%h",
                         i, out_valid, in_ready, out_data, ea[63:0]);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = db;
        in_mode   = MODE_ABS;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_same_edge_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = {$urandom, $urandom};
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_valid_drop: got %b expected 0", out_valid);
        end
        wait_valid(cyc);
        n_tests++;
        if (cyc != 4 || {out_ovf, out_carry, out_data} !== eb) begin
            n_fail++;
            $display("FAIL bp_second: got lat=%0d data=%h expected lat=4 data=%h", cyc, out_data, eb[63:0]);
        end
        retire();
    endtask

    task automatic test_reset_midop();
        bit to;
        send(64'h0000_0000_0000_0042, MODE_TWOS, to);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_tests++;
        if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_midop: got valid=%b ready=%b data=%h expected 0 1 0",
                     out_valid, in_ready, out_data);
        end
        check_op("after_reset", 64'h5, MODE_TWOS, 1'b1);
    endtask

    task automatic test_input_stability();
        bit          to;
        int          cyc;
        logic [65:0] exp;
        exp = model(64'h0000_0000_DEAD_BEEF, MODE_TWOS);
        send(64'h0000_0000_DEAD_BEEF, MODE_TWOS, to);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            in_data = {$urandom, $urandom};
            in_mode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (cyc != 4 || {out_ovf, out_carry, out_data} !== exp) begin
            n_fail++;
            $display("FAIL stability: got lat=%0d data=%h expected lat=4 data=%h", cyc, out_data, exp[63:0]);
        end
        retire();
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [1:0]  m;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: d = 64'd0;
                1: d = MINNEG;
                2: d = 64'($urandom_range(0, 3)) << (16 * $urandom_range(0, 3));
                default: d = {$urandom, $urandom};
            endcase
            m = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check_op("random", d, m, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_input_stability();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
